mem_requester: RTL and testbench

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_requester.sv | 164 ++++++++++++++++
 tb/tb_mem_requester.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// mem_requester: serialises CPU load/store requests onto a single-ported,
// word-wide memory with a combinational read port. Sub-word stores are done
// as read-modify-write; sub-word loads are lane-selected and extended.
// Lanes are big-endian (byte offset 0 = bits 31:24).
//
// Ports
//   clock, reset          system clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write/size/signed/addr/wdata   request fields, captured at handshake
//   rsp_valid/rsp_rdata/rsp_err        one-cycle completion pulse and result
//   mem_ren/mem_wen/mem_addr/mem_din   word-memory control (word index address)
//   mem_dout                           combinational read word
//
// state   | meaning
// IDLE    | ready for a request
// RD      | load: memory read, result captured at end of cycle
// WR      | word store: memory write
// RMW_RD  | sub-word store: read the containing word
// RMW_WR  | sub-word store: write the word back with the lane(s) replaced
// RESP    | rsp_valid pulse, then back to IDLE
module mem_requester (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rmw_q;
    logic [31:0] result_q;

    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Rejected requests never touch memory; the address window is 4 KiB.
    always_comb begin
        req_err = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (|req_addr[1:0]))
                | (|req_addr[31:12]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (!req_write)
                        state_nxt = RD;
                    else if (req_size == 2'b10)
                        state_nxt = WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            RD:      state_nxt = RESP;
            WR:      state_nxt = RESP;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_sel = mem_dout[31:24];
            2'd1: byte_sel = mem_dout[23:16];
            2'd2: byte_sel = mem_dout[15:8];
            2'd3: byte_sel = mem_dout[7:0];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_q[1] ? mem_dout[15:0] : mem_dout[31:16];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_dout;
        endcase
    end

    // Store data is right-justified; only its low byte/halfword is used.
    always_comb begin
        merged = rmw_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[31:24] = wdata_q[7:0];
                2'd1: merged[23:16] = wdata_q[7:0];
                2'd2: merged[15:8]  = wdata_q[7:0];
                2'd3: merged[7:0]   = wdata_q[7:0];
                default: merged = rmw_q;
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = wdata_q[15:0];
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rmw_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                size_q   <= req_size;
                signed_q <= req_signed;
                err_q    <= req_err;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                result_q <= '0;
            end
            if (state == RD)
                result_q <= load_ext;
            if (state == RMW_RD)
                rmw_q <= mem_dout;
        end
    end

    // Outputs decode the state and registered request only, so they are
    // glitch-free and constant across every memory-access cycle.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? result_q : '0;
    assign mem_ren   = (state == RD) | (state == RMW_RD);
    assign mem_wen   = (state == WR) | (state == RMW_WR);
    assign mem_addr  = (mem_ren | mem_wen) ? {2'b00, addr_q[31:2]} : '0;
    assign mem_din   = (state == WR)     ? wdata_q :
                       (state == RMW_WR) ? merged  : '0;

endmodule

// File: tb/tb_mem_requester.sv
module tb_mem_requester;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];
    logic [7:0]  ref_mem [0:4095];

    int n_vec = 0;
    int n_err = 0;

    // results of the last do_req
    int          o_lat, o_nren, o_nwen, o_ren_k, o_wen_k;
    logic [31:0] o_rdata, o_addr;
    logic        o_err, o_both;

    mem_requester dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    assign mem_dout = mem[mem_addr[9:0]];
    always @(posedge clock) if (mem_wen) mem[mem_addr[9:0]] <= mem_din;

    // Issue one request from IDLE, observe until the response (max 8 cycles),
    // then step one more cycle so the DUT is back in IDLE.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        o_lat = 0; o_nren = 0; o_nwen = 0; o_ren_k = 0; o_wen_k = 0;
        o_rdata = 'x; o_addr = 'x; o_err = 1'bx; o_both = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_ren && mem_wen) o_both = 1'b1;
            if (mem_ren) begin o_nren++; o_ren_k = k; o_addr = mem_addr; end
            if (mem_wen) begin o_nwen++; o_wen_k = k; o_addr = mem_addr; end
            if (rsp_valid) begin
                o_lat = k; o_rdata = rsp_rdata; o_err = rsp_err;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        repeat (3) @(posedge clock);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
        n_vec++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin n_err++; $display("FAIL rst_mem_en got ren=%b wen=%b want 0 0", mem_ren, mem_wen); end
        n_vec++; if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin n_err++; $display("FAIL rst_mem_bus got addr=%h din=%h want 0 0", mem_addr, mem_din); end
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (req_ready !== 1'b1 || mem_ren !== 1'b0) begin n_err++; $display("FAIL rst_release got ready=%b ren=%b want 1 0", req_ready, mem_ren); end
    endtask

    task automatic test_word_store_load;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        n_vec++; if (o_lat != 2 || o_nwen != 1 || o_nren != 0 || o_addr !== 32'd4 || o_err !== 1'b0 || o_rdata !== 32'h0)
            begin n_err++; $display("FAIL wst lat=%0d wen=%0d ren=%0d addr=%h err=%b rdata=%h want 2 1 0 4 0 0", o_lat, o_nwen, o_nren, o_addr, o_err, o_rdata); end
        n_vec++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_mem got %h want deadbeef", mem[4]); end
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL wst_after got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_vec++; if (o_lat != 2 || o_rdata !== 32'hDEADBEEF || o_nren != 1 || o_nwen != 0 || o_addr !== 32'd4)
            begin n_err++; $display("FAIL wld lat=%0d rdata=%h ren=%0d wen=%0d addr=%h want 2 deadbeef 1 0 4", o_lat, o_rdata, o_nren, o_nwen, o_addr); end
    endtask

    task automatic test_subword_store;
        logic [31:0] t_addr [5] = '{32'h11, 32'h12, 32'h13, 32'h10, 32'h10};
        logic [1:0]  t_size [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        logic [31:0] t_wd   [5] = '{32'h123456AA, 32'hFFFFBEEF, 32'h00000055, 32'h0000009A, 32'hAAAA0102};
        logic [31:0] t_exp  [5] = '{32'h11AA3344, 32'h11AABEEF, 32'h11AABE55, 32'h9AAABE55, 32'h0102BE55};
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1, t_size[i], 1'b0, t_addr[i], t_wd[i]);
            n_vec++; if (o_lat != 3 || o_ren_k != 1 || o_wen_k != 2 || o_nren != 1 || o_nwen != 1 || o_addr !== 32'd4 || o_both)
                begin n_err++; $display("FAIL rmw_seq%0d lat=%0d renk=%0d wenk=%0d addr=%h want 3 1 2 4", i, o_lat, o_ren_k, o_wen_k, o_addr); end
            n_vec++; if (mem[4] !== t_exp[i]) begin n_err++; $display("FAIL rmw_mem%0d got %h want %h", i, mem[4], t_exp[i]); end
        end
    endtask

    task automatic test_load_ext;
        logic [31:0] t_addr [8] = '{32'h10, 32'h11, 32'h12, 32'h10, 32'h10, 32'h13, 32'h12, 32'h10};
        logic [1:0]  t_size [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
        logic        t_sg   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] t_exp  [8] = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'hFFFF80FF,
                                    32'h000080FF, 32'h00000001, 32'h0000007F, 32'h80FF7F01};
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, t_size[i], t_sg[i], t_addr[i], 32'hFFFFFFFF);
            n_vec++; if (o_lat != 2 || o_rdata !== t_exp[i] || o_err !== 1'b0 || o_nwen != 0)
                begin n_err++; $display("FAIL ld_ext%0d lat=%0d rdata=%h err=%b want 2 %h 0", i, o_lat, o_rdata, o_err, t_exp[i]); end
        end
    endtask

    task automatic test_errors;
        logic        t_w    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  t_size [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00};
        logic [31:0] t_addr [6] = '{32'h13, 32'h11, 32'h10, 32'h1000, 32'h12, 32'h80000010};
        for (int i = 0; i < 6; i++) begin
            do_req(t_w[i], t_size[i], 1'b1, t_addr[i], 32'h5A5A5A5A);
            n_vec++; if (o_lat != 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_nren != 0 || o_nwen != 0)
                begin n_err++; $display("FAIL err%0d lat=%0d err=%b rdata=%h ren=%0d wen=%0d want 1 1 0 0 0", i, o_lat, o_err, o_rdata, o_nren, o_nwen); end
        end
        n_vec++; if (mem[4] !== 32'h80FF7F01) begin n_err++; $display("FAIL err_mem got %h want 80ff7f01", mem[4]); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int hs = 0;
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h20;
        req_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (req_ready) hs++;
            @(posedge clock); #1;
            if (rsp_valid) begin
                pulses++;
                n_vec++; if (rsp_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_rdata got %h want cafef00d", rsp_rdata); end
            end
        end
        req_valid = 1'b0;
        n_vec++; if (pulses != 3 || hs != 3) begin n_err++; $display("FAIL b2b_rate got rsp=%0d hs=%0d want 3 3", pulses, hs); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle got ready=%b want 1", req_ready); end
    endtask

    task automatic test_reset_mid;
        logic bad = 1'b0;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'hAA;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n_vec++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0) begin n_err++; $display("FAIL mid_rmwrd got ren=%b wen=%b want 1 0", mem_ren, mem_wen); end
        reset = 1'b0;
        @(posedge clock); #1;
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
                     mem_ren !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 32'h0 || mem_din !== 32'h0)
            begin n_err++; $display("FAIL mid_reset got ready=%b v=%b e=%b rd=%h ren=%b wen=%b a=%h d=%h", req_ready, rsp_valid, rsp_err, rsp_rdata, mem_ren, mem_wen, mem_addr, mem_din); end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            if (rsp_valid || mem_wen || mem_ren) bad = 1'b1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL mid_quiet got activity=1 want 0"); end
        n_vec++; if (mem[4] !== 32'h11223344) begin n_err++; $display("FAIL mid_mem got %h want 11223344", mem[4]); end
    endtask

    task automatic test_random;
        logic [31:0] e_rdata, wd;
        logic [11:0] a;
        logic [1:0]  sz;
        logic        e_err, hs, pending, both;
        logic [7:0]  b;
        logic [15:0] h;
        int n_hs = 0;
        int n_rsp = 0;
        pending = 1'b0; both = 1'b0; e_rdata = '0; e_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wd = $urandom;
            do_req(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4 * i), wd);
            for (int j = 0; j < 4; j++) ref_mem[64 + 4 * i + j] = wd[31 - 8 * j -: 8];
        end
        req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1)); req_wdata = $urandom;
        req_addr = 32'($urandom_range(64, 79));
        for (int c = 0; c < 306; c++) begin
            req_valid = (c < 300);
            if (mem_ren && mem_wen) both = 1'b1;
            if (rsp_valid) begin
                n_rsp++;
                n_vec++; if (!pending || rsp_err !== e_err || rsp_rdata !== e_rdata)
                    begin n_err++; $display("FAIL rnd_rsp c=%0d got err=%b rdata=%h want err=%b rdata=%h pend=%b", c, rsp_err, rsp_rdata, e_err, e_rdata, pending); end
                pending = 1'b0;
            end
            hs = req_ready && req_valid;
            if (hs) begin
                n_hs++;
                pending = 1'b1;
                a = req_addr[11:0]; sz = req_size;
                e_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (req_addr[31:12] != 20'h0);
                e_rdata = '0;
                if (!e_err && !req_write) begin
                    b = ref_mem[a];
                    h = {ref_mem[a], ref_mem[a + 12'd1]};
                    if (sz == 2'b00) e_rdata = {{24{req_signed & b[7]}}, b};
                    else if (sz == 2'b01) e_rdata = {{16{req_signed & h[15]}}, h};
                    else e_rdata = {ref_mem[a], ref_mem[a + 12'd1], ref_mem[a + 12'd2], ref_mem[a + 12'd3]};
                end else if (!e_err) begin
                    if (sz == 2'b00) ref_mem[a] = req_wdata[7:0];
                    else if (sz == 2'b01) begin ref_mem[a] = req_wdata[15:8]; ref_mem[a + 12'd1] = req_wdata[7:0]; end
                    else begin
                        ref_mem[a] = req_wdata[31:24]; ref_mem[a + 12'd1] = req_wdata[23:16];
                        ref_mem[a + 12'd2] = req_wdata[15:8]; ref_mem[a + 12'd3] = req_wdata[7:0];
                    end
                end
            end
            @(posedge clock); #1;
            if (hs) begin
                req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
                req_signed = 1'($urandom_range(0, 1)); req_wdata = $urandom;
                req_addr = 32'($urandom_range(64, 79));
                if ($urandom_range(0, 7) == 0) req_addr = req_addr | 32'h1000;
            end
        end
        req_valid = 1'b0;
        n_vec++; if (both) begin n_err++; $display("FAIL rnd_exclusive got ren&wen=1 want 0"); end
        n_vec++; if (pending || n_rsp != n_hs || n_hs < 50) begin n_err++; $display("FAIL rnd_count got rsp=%0d hs=%0d pend=%b want equal", n_rsp, n_hs, pending); end
    endtask

    initial begin
        test_reset;
        test_word_store_load;
        test_subword_store;
        test_load_ext;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
